// File: rtl/mtr_pkg.sv
// Shared types and defaults for the motor PWM loop-back decoder.
// Magnitude width and PWM period are tied: 2^MAG_W == PERIOD.
package mtr_pkg;

    localparam int PERIOD = 1024;
    localparam int MAG_W  = 10;
    localparam int CMD_W  = MAG_W + 1;

    typedef struct packed {
        logic             dir;
        logic [MAG_W-1:0] mag;
    } mtr_cmd_t;

endpackage

// File: rtl/mtr_pwm_chan.sv
// One motor channel: fwd/rev high-time counters, window-end decision, sticky flags.
// Latency: meas and flags register on the edge after the deciding sample.
// Backpressure: none; a sample is consumed every clock.
module mtr_pwm_chan
    import mtr_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     fwd,
    input  logic     rev,
    input  logic     win_end,
    input  logic     clr,
    input  logic     clr_fault,
    output mtr_cmd_t meas,
    output logic     shoot,
    output logic     mix
);

    localparam logic [MAG_W-1:0] CNT_MAX = {MAG_W{1'b1}};

    logic [MAG_W-1:0] fwd_cnt_q, fwd_cnt_d;
    logic [MAG_W-1:0] rev_cnt_q, rev_cnt_d;
    logic [MAG_W-1:0] fwd_tot, rev_tot;
    mtr_cmd_t         meas_q, meas_d;
    logic             shoot_q, shoot_d;
    logic             mix_q, mix_d;

    always_comb begin
        // Totals include the current sample so the window-end cycle counts.
        fwd_tot   = (fwd && (fwd_cnt_q != CNT_MAX)) ? fwd_cnt_q + 1'b1 : fwd_cnt_q;
        rev_tot   = (rev && (rev_cnt_q != CNT_MAX)) ? rev_cnt_q + 1'b1 : rev_cnt_q;
        fwd_cnt_d = fwd_tot;
        rev_cnt_d = rev_tot;
        meas_d    = meas_q;
        shoot_d   = (shoot_q & ~clr_fault) | (fwd & rev);
        mix_d     = mix_q & ~clr_fault;

        if (win_end) begin
            fwd_cnt_d = '0;
            rev_cnt_d = '0;
            if (rev_tot == '0) begin
                meas_d = '{dir: 1'b0, mag: fwd_tot};
            end else if (fwd_tot == '0) begin
                meas_d = '{dir: 1'b1, mag: rev_tot};
            end else begin
                mix_d = 1'b1;
            end
        end

        if (clr) begin
            fwd_cnt_d = '0;
            rev_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fwd_cnt_q <= '0;
            rev_cnt_q <= '0;
            meas_q    <= '0;
            shoot_q   <= 1'b0;
            mix_q     <= 1'b0;
        end else begin
            fwd_cnt_q <= fwd_cnt_d;
            rev_cnt_q <= rev_cnt_d;
            meas_q    <= meas_d;
            shoot_q   <= shoot_d;
            mix_q     <= mix_d;
        end
    end

    assign meas  = meas_q;
    assign shoot = shoot_q;
    assign mix   = mix_q;

endmodule

// File: rtl/mtr_pwm_decoder.sv
// Loop-back monitor rebuilding left/right signed-magnitude commands from PWM pins.
// Latency: meas/meas_vld one edge after window end; +2 cycles pin delay with MTR_DEC_SYNC_EN.
// Backpressure: none; meas_vld is a one-cycle pulse with no ready.
module mtr_pwm_decoder #(
    parameter int PERIOD = mtr_pkg::PERIOD,
    parameter int MAG_W  = mtr_pkg::MAG_W
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           fwd_lft,
    input  logic           rev_lft,
    input  logic           fwd_rht,
    input  logic           rev_rht,
    input  logic           win_clr,
    input  logic           clr_fault,
    output logic [MAG_W:0] lft_meas,
    output logic [MAG_W:0] rht_meas,
    output logic           meas_vld,
    output logic           shoot_lft,
    output logic           shoot_rht,
    output logic           mix_lft,
    output logic           mix_rht
);

    import mtr_pkg::*;

    logic [3:0] pins;

`ifdef MTR_DEC_SYNC_EN
    logic [3:0] pin_s1_q, pin_s2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pin_s1_q <= '0;
            pin_s2_q <= '0;
        end else begin
            pin_s1_q <= {fwd_lft, rev_lft, fwd_rht, rev_rht};
            pin_s2_q <= pin_s1_q;
        end
    end

    assign pins = pin_s2_q;
`else
    assign pins = {fwd_lft, rev_lft, fwd_rht, rev_rht};
`endif

    logic [MAG_W-1:0] win_cnt_q, win_cnt_d;
    logic             win_end;
    logic             chan_end;
    logic             meas_vld_q, meas_vld_d;

    always_comb begin
        win_end    = (win_cnt_q == MAG_W'(PERIOD - 1));
        // A restart on the boundary cycle suppresses that window's result.
        chan_end   = win_end & ~win_clr;
        win_cnt_d  = win_end ? '0 : win_cnt_q + 1'b1;
        if (win_clr) begin
            win_cnt_d = '0;
        end
        meas_vld_d = chan_end;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_cnt_q  <= '0;
            meas_vld_q <= 1'b0;
        end else begin
            win_cnt_q  <= win_cnt_d;
            meas_vld_q <= meas_vld_d;
        end
    end

    mtr_cmd_t lft_cmd, rht_cmd;

    mtr_pwm_chan u_lft (
        .clk       (clk),
        .rst       (rst),
        .fwd       (pins[3]),
        .rev       (pins[2]),
        .win_end   (chan_end),
        .clr       (win_clr),
        .clr_fault (clr_fault),
        .meas      (lft_cmd),
        .shoot     (shoot_lft),
        .mix       (mix_lft)
    );

    mtr_pwm_chan u_rht (
        .clk       (clk),
        .rst       (rst),
        .fwd       (pins[1]),
        .rev       (pins[0]),
        .win_end   (chan_end),
        .clr       (win_clr),
        .clr_fault (clr_fault),
        .meas      (rht_cmd),
        .shoot     (shoot_rht),
        .mix       (mix_rht)
    );

    assign lft_meas = lft_cmd;
    assign rht_meas = rht_cmd;
    assign meas_vld = meas_vld_q;

endmodule

// File: tb/tb_mtr_pwm_decoder.sv
// Self-checking bench for mtr_pwm_decoder (default build, pins sampled directly).
module tb_mtr_pwm_decoder;

    localparam int P = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fwd_lft = 1'b0, rev_lft = 1'b0, fwd_rht = 1'b0, rev_rht = 1'b0;
    logic        win_clr = 1'b0, clr_fault = 1'b0;
    logic [10:0] lft_meas, rht_meas;
    logic        meas_vld, shoot_lft, shoot_rht, mix_lft, mix_rht;

    int total = 0;
    int bad   = 0;

    // Reference state: last published commands and expected sticky flags.
    logic [10:0] m_lft = 11'h000, m_rht = 11'h000;
    bit          f_sl = 0, f_sr = 0, f_ml = 0, f_mr = 0;

    always #5 clk = ~clk;

    mtr_pwm_decoder dut (
        .clk       (clk),
        .rst       (rst),
        .fwd_lft   (fwd_lft),
        .rev_lft   (rev_lft),
        .fwd_rht   (fwd_rht),
        .rev_rht   (rev_rht),
        .win_clr   (win_clr),
        .clr_fault (clr_fault),
        .lft_meas  (lft_meas),
        .rht_meas  (rht_meas),
        .meas_vld  (meas_vld),
        .shoot_lft (shoot_lft),
        .shoot_rht (shoot_rht),
        .mix_lft   (mix_lft),
        .mix_rht   (mix_rht)
    );

    // Command a window yields given how many cycles each pin was high.
    function automatic logic [10:0] decide(input logic [10:0] prev, input int nf, input int nr,
                                           output bit mixed);
        int cf = (nf > 1023) ? 1023 : nf;
        int cr = (nr > 1023) ? 1023 : nr;
        mixed = 0;
        if (cr == 0) return {1'b0, 10'(cf)};
        if (cf == 0) return {1'b1, 10'(cr)};
        mixed = 1;
        return prev;
    endfunction

    task automatic check_all_outputs_zero(input string name);
        total++;
        if ({lft_meas, rht_meas} !== 22'h0) begin
            bad++;
            $display("FAIL %s meas got lft=%h rht=%h exp 000/000", name, lft_meas, rht_meas);
        end
        total++;
        if ({meas_vld, shoot_lft, shoot_rht, mix_lft, mix_rht} !== 5'b0) begin
            bad++;
            $display("FAIL %s vld/flags got %b exp 00000", name,
                     {meas_vld, shoot_lft, shoot_rht, mix_lft, mix_rht});
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_all_outputs_zero("reset");
        rst = 1'b0;
    endtask

    // Drives one full window starting at a negedge aligned to win_cnt==0.
    // Pins are given as [start, start+len) intervals; clr_at pulses clr_fault (-1 = none).
    task automatic run_window(input string name,
                              input int lfs, input int lfn, input int lrs, input int lrn,
                              input int rfs, input int rfn, input int rrs, input int rrn,
                              input int clr_at);
        int          vld_mid = 0;
        bit          mxl, mxr;
        logic [10:0] el, er;
        el = decide(m_lft, lfn, lrn, mxl);
        er = decide(m_rht, rfn, rrn, mxr);
        for (int i = 0; i < P; i++) begin
            bit fl = (i >= lfs) && (i < lfs + lfn);
            bit rl = (i >= lrs) && (i < lrs + lrn);
            bit fr = (i >= rfs) && (i < rfs + rfn);
            bit rr = (i >= rrs) && (i < rrs + rrn);
            fwd_lft   = fl;
            rev_lft   = rl;
            fwd_rht   = fr;
            rev_rht   = rr;
            clr_fault = (i == clr_at);
            @(posedge clk);
            @(negedge clk);
            if (i == clr_at) begin
                f_sl = 0; f_sr = 0; f_ml = 0; f_mr = 0;
            end
            if (fl && rl) f_sl = 1;
            if (fr && rr) f_sr = 1;
            if (i < P - 1) begin
                if (meas_vld) vld_mid++;
                if ((fl && rl) || (fr && rr) || (i == clr_at)) begin
                    total++;
                    if ({shoot_lft, shoot_rht, mix_lft, mix_rht} !== {f_sl, f_sr, f_ml, f_mr}) begin
                        bad++;
                        $display("FAIL %s mid-window flags @%0d got %b exp %b", name, i,
                                 {shoot_lft, shoot_rht, mix_lft, mix_rht}, {f_sl, f_sr, f_ml, f_mr});
                    end
                end
            end
        end
        clr_fault = 1'b0;
        if (mxl) f_ml = 1;
        if (mxr) f_mr = 1;
        m_lft = el;
        m_rht = er;
        total++;
        if (vld_mid !== 0) begin
            bad++;
            $display("FAIL %s early meas_vld got %0d pulses exp 0", name, vld_mid);
        end
        total++;
        if (meas_vld !== 1'b1) begin
            bad++;
            $display("FAIL %s meas_vld at window end got %b exp 1", name, meas_vld);
        end
        total++;
        if (lft_meas !== el) begin
            bad++;
            $display("FAIL %s lft_meas got %h exp %h", name, lft_meas, el);
        end
        total++;
        if (rht_meas !== er) begin
            bad++;
            $display("FAIL %s rht_meas got %h exp %h", name, rht_meas, er);
        end
        total++;
        if ({shoot_lft, shoot_rht, mix_lft, mix_rht} !== {f_sl, f_sr, f_ml, f_mr}) begin
            bad++;
            $display("FAIL %s end flags got %b exp %b", name,
                     {shoot_lft, shoot_rht, mix_lft, mix_rht}, {f_sl, f_sr, f_ml, f_mr});
        end
    endtask

    // n cycles from a window start, fwd_lft high the first lfn, win_clr on the last.
    task automatic run_partial(input string name, input int n, input int lfn);
        int vc = 0;
        rev_lft = 1'b0; fwd_rht = 1'b0; rev_rht = 1'b0;
        for (int i = 0; i < n; i++) begin
            fwd_lft = (i < lfn);
            win_clr = (i == n - 1);
            @(posedge clk);
            @(negedge clk);
            if (meas_vld) vld_mid_inc(vc);
        end
        win_clr = 1'b0;
        total++;
        if (vc !== 0) begin
            bad++;
            $display("FAIL %s meas_vld before/at win_clr got %0d pulses exp 0", name, vc);
        end
        total++;
        if ({lft_meas, rht_meas} !== {m_lft, m_rht}) begin
            bad++;
            $display("FAIL %s held meas got %h/%h exp %h/%h", name, lft_meas, rht_meas, m_lft, m_rht);
        end
    endtask

    task automatic vld_mid_inc(inout int c);
        c++;
    endtask

    task automatic test_idle();
        run_window("idle", 0, 0, 0, 0, 0, 0, 0, 0, -1);
    endtask

    task automatic test_basic();
        run_window("basic_fwd100_rev_sat", 0, 100, 0, 0, 0, 0, 0, 1024, -1);
    endtask

    task automatic test_mix();
        run_window("mix_w1", 10, 300, 0, 0, 0, 0, 0, 0, -1);
        run_window("mix_w2", 0, 300, 600, 5, 0, 0, 0, 0, -1);
    endtask

    task automatic test_shoot();
        run_window("shoot_set", 0, 0, 0, 0, 400, 1, 400, 1, -1);
        run_window("shoot_clr", 0, 0, 0, 0, 0, 0, 0, 0, 100);
        run_window("shoot_clr_vs_set", 0, 0, 0, 0, 200, 1, 200, 1, 200);
        run_window("shoot_clean", 0, 0, 0, 0, 0, 0, 0, 0, 5);
    endtask

    task automatic test_win_clr();
        run_partial("win_clr_mid", 501, 200);
        run_window("after_win_clr", 0, 77, 0, 0, 0, 0, 0, 0, -1);
        run_partial("win_clr_at_end", 1024, 50);
        run_window("after_win_clr_end", 3, 9, 0, 0, 0, 0, 0, 0, -1);
    endtask

    task automatic test_reset_mid();
        fwd_lft = 1'b1;
        repeat (300) @(negedge clk);
        rst = 1'b1;
        #1;
        check_all_outputs_zero("reset_mid");
        m_lft = 11'h000; m_rht = 11'h000;
        f_sl = 0; f_sr = 0; f_ml = 0; f_mr = 0;
        fwd_lft = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        run_window("after_reset_mid", 0, 0, 0, 0, 0, 0, 0, 0, -1);
    endtask

    task automatic rand_chan(output int fs, output int fn, output int rs, output int rn);
        int mode = $urandom_range(0, 3);
        fn = (mode == 0 || mode == 2) ? $urandom_range(1, P) : 0;
        rn = (mode == 1 || mode == 2) ? $urandom_range(1, P) : 0;
        fs = $urandom_range(0, P - fn);
        rs = $urandom_range(0, P - rn);
    endtask

    task automatic test_random();
        for (int w = 0; w < 8; w++) begin
            int lfs, lfn, lrs, lrn, rfs, rfn, rrs, rrn, ca;
            rand_chan(lfs, lfn, lrs, lrn);
            rand_chan(rfs, rfn, rrs, rrn);
            ca = ($urandom_range(0, 2) == 0) ? $urandom_range(0, P - 1) : -1;
            run_window("random", lfs, lfn, lrs, lrn, rfs, rfn, rrs, rrn, ca);
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_basic();
        test_mix();
        test_shoot();
        test_win_clr();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
